iob_2p_mem_stream_reader: RTL and testbench
===========================================

// Module: iob_2p_mem_stream_reader
// PURPOSE
//  Read-side engine for an iob_2p_mem_tiled instance. On start, reads LENGTH consecutive words from
//  BASE_ADDR over the memory read port (r_en/addr/data_out, 1-cycle read latency) and delivers them
//  in order on a valid/ready output stream. A 2-entry output buffer absorbs backpressure without
//  losing in-flight reads. Sits between the tiled memory and any stream consumer (DMA, UART TX, ...).
// PARAMETERS
//  DATA_W   16  word width, equal to the memory DATA_W
//  ADDR_W   14  memory word-address width
//  LEN_W    14  width of the transfer-length field, in words
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle request; sampled only in IDLE
//  base_addr    in   ADDR_W  first word address, latched on accepted start
//  length       in   LEN_W   number of words to read, latched on accepted start
//  busy         out  1       high from accepted start until the done cycle, inclusive
//  done         out  1       1-cycle pulse when the transfer completes
//  mem_r_en     out  1       memory read enable
//  mem_addr     out  ADDR_W  memory read address
//  mem_data     in   DATA_W  memory data_out; valid the cycle after mem_r_en=1
//  out_valid    out  1       output word available
//  out_ready    in   1       consumer accepts word when out_valid & out_ready
//  out_data     out  DATA_W  output word
//  out_last     out  1       high with the final word of the transfer
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy, done, mem_r_en, out_valid, out_last = 0; mem_addr,
//    out_data = 0; buffer emptied; in-flight read discarded. Reset mid-transfer aborts it, and no done is issued.
//  - FSM states: IDLE, READ, DRAIN.
//    IDLE:  start=1 & length!=0 -> latch addr/remaining -> READ, busy=1 next cycle.
//           start=1 & length==0 -> done=1 and busy=1 for exactly the next cycle, no reads -> IDLE.
//    READ:  issue a read (mem_r_en=1, mem_addr=cur_addr) in any cycle where remaining!=0 and
//           buf_count + inflight + (1 if no pop this cycle else 0) <= 2, i.e. never overfill the buffer.
//           Each issue: cur_addr+=1 (wraps mod 2^ADDR_W, 2^ADDR_W-1 -> 0), remaining-=1.
//           remaining reaches 0 -> DRAIN.
//    DRAIN: no further reads. When the last word is popped (out_valid&out_ready&out_last), done=1
//           and busy=1 that cycle; busy=0 from the next cycle -> IDLE.
//  - mem_r_en is 0 whenever no read is issued. mem_data is captured only in the cycle after an
//    issued read; its value in other cycles (held or 0) is ignored.
//  - Latency: with out_ready held high, the first word is on out_data 2 cycles after the start
//    cycle (1 cycle start->issue, 1 cycle memory). Sustained throughput is 1 word/cycle.
//  - Buffer: 2-entry FIFO, head drives out_valid/out_data/out_last. Push and pop in the same
//    cycle are allowed when full or empty. out_data/out_last are stable while out_valid & !out_ready.
//  - out_last is tagged at issue time on the read that takes remaining from 1 to 0.
//  - start while busy is ignored; base_addr/length changes while busy have no effect.
//  - Words are delivered in address order; no word is dropped or duplicated under any out_ready pattern.
// TESTING (memory preloaded with mem[i]=i+32 for i=0..15, DATA_W=16)
//  1 base=0, len=16, out_ready=1 -> out_data 32..47 on 16 consecutive cycles; out_last on 47;
//    done 1 cycle after 47 is accepted; mem_r_en high exactly 16 cycles.
//  2 base=4, len=6, out_ready toggled 1,0,0,1,... -> stream 36..41 with no loss or duplicate;
//    out_data held while stalled; never more than 2 reads outstanding beyond consumed words.
//  3 len=0 -> done pulse and busy for 1 cycle, mem_r_en never asserted, out_valid stays 0.
//  4 base=2^ADDR_W-2, len=4 -> mem_addr sequence 16382,16383,0,1; last word flagged out_last.
//  5 rst_n=0 after 5 words of a 16-word transfer -> all outputs 0 immediately; after release,
//    new start base=8, len=2 -> 40,41 only, with no stale word emitted.
//  6 start pulsed again mid-transfer with different base/len -> ignored; original stream completes.

Source files
------------

// File: rtl/iob_2p_mem_stream_reader.sv
// Read-side streaming engine for a two-port tiled memory.
// Reads a block of consecutive words and presents them in address order on a
// valid/ready stream. A 2-entry buffer holds words the consumer has not taken
// yet, so reads already issued to the memory are never lost under backpressure.
// A word returning from memory bypasses the buffer when the buffer is empty, so
// the first word reaches out_data two cycles after the start cycle.

module iob_2p_mem_stream_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;

    logic [DATA_W-1:0]  buf_data_q [2];
    logic               buf_last_q [2];
    logic               rd_ptr_q, wr_ptr_q;
    logic [1:0]         count_q, count_d;

    logic               accept;
    logic               issue;
    logic               pop;
    logic               pop_buf;
    logic               push;
    logic               buf_empty;
    logic [2:0]         occupancy;

    // Stream head: the oldest buffered word, or the word arriving from memory
    // this cycle when nothing is buffered ahead of it.
    always_comb begin
        buf_empty = (count_q == 2'd0);
        out_valid = !buf_empty || inflight_q;
        out_data  = '0;
        out_last  = 1'b0;
        if (!buf_empty) begin
            out_data = buf_data_q[rd_ptr_q];
            out_last = buf_last_q[rd_ptr_q];
        end else if (inflight_q) begin
            out_data = mem_data;
            out_last = inflight_last_q;
        end
        pop     = out_valid && out_ready;
        pop_buf = pop && !buf_empty;
        push    = inflight_q && !(pop && buf_empty);
        count_d = count_q + {1'b0, push} - {1'b0, pop_buf};
    end

    // Read issue: only issue when the returning word is guaranteed a slot,
    // counting buffered words, the word in flight and whether one leaves now.
    always_comb begin
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} + {2'b00, ~pop};
        accept    = (state_q == IDLE) && !busy_q && start;
        issue     = (state_q == READ) && (remaining_q != '0) && (occupancy <= 3'd2);
        mem_r_en  = issue;
        mem_addr  = issue ? cur_addr_q : '0;
    end

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        remaining_d     = remaining_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == LEN_W'(1));
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (length != '0) begin
                        cur_addr_d  = base_addr;
                        remaining_d = length;
                        state_d     = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE) || done_d;
    end

    // Sequencer and read-tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remaining_q     <= remaining_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // Two-entry output buffer; captures memory data only in the cycle after an issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= mem_data;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop_buf) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_iob_2p_mem_stream_reader.sv
// Bench for the memory stream reader: a registered 1-cycle-latency memory model
// holding mem[i] = i + 32, directed transfers, and a scoreboard queue checked
// by an independent output monitor.

module tb_iob_2p_mem_stream_reader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam int LEN_W  = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy;
    logic              done;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic [DATA_W-1:0] mem [DEPTH];

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;

    logic [DATA_W-1:0] expData[$];
    logic              expLast[$];
    int                addrLog[$];

    int   readCount, popCount, doneCount, busyCount, validCount;
    int   startCycle, doneCycle, firstPopCycle, lastPopCycle;
    int   firstReadCycle, lastReadCycle, maxOutstanding;
    logic stallHeld = 1'b0;
    logic [DATA_W-1:0] stallData;
    logic stallLast;

    iob_2p_mem_stream_reader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .mem_r_en (mem_r_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory contents and registered read port
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i + 32);
    end

    always @(posedge clk) begin
        if (mem_r_en) mem_data <= mem[mem_addr];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted word, checks hold-while-stalled
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_r_en) begin
                if (readCount == 0) firstReadCycle = cycle;
                lastReadCycle = cycle;
                readCount++;
                addrLog.push_back(int'(mem_addr));
            end
            if (busy) busyCount++;
            if (out_valid) validCount++;
            if (done) begin
                doneCount++;
                doneCycle = cycle;
                checkOutput("busy_during_done", int'(busy), 1);
            end
            if (stallHeld) begin
                checkOutput("stall_valid", int'(out_valid), 1);
                checkOutput("stall_data", int'(out_data), int'(stallData));
                checkOutput("stall_last", int'(out_last), int'(stallLast));
            end
            if (out_valid && out_ready) begin
                if (expData.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_word: got %0d, expected no word", out_data);
                end else begin
                    checkOutput("word_data", int'(out_data), int'(expData.pop_front()));
                    checkOutput("word_last", int'(out_last), int'(expLast.pop_front()));
                end
                if (popCount == 0) firstPopCycle = cycle;
                if (out_last) lastPopCycle = cycle;
                popCount++;
            end
            if (readCount - popCount > maxOutstanding) maxOutstanding = readCount - popCount;
            stallHeld = out_valid && !out_ready;
            stallData = out_data;
            stallLast = out_last;
        end else begin
            stallHeld = 1'b0;
        end
    end

    task automatic clearCounters();
        readCount = 0; popCount = 0; doneCount = 0; busyCount = 0; validCount = 0;
        doneCycle = -1; firstPopCycle = -1; lastPopCycle = -1;
        firstReadCycle = -1; lastReadCycle = -1; maxOutstanding = 0;
        addrLog.delete();
    endtask

    task automatic pushExpected(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            expData.push_back(16'(((base + i) % DEPTH) + 32));
            expLast.push_back(i == len - 1);
        end
    endtask

    // Runs one transfer; readyMode 0 = always ready, 1 = ready pattern 1,0,0,1
    task automatic applyStimulus(input int base, input int len, input int readyMode, input int restartAt);
        logic [3:0] pat;
        logic       finished;
        pat = 4'b1001;
        finished = 1'b0;
        clearCounters();
        pushExpected(base, len);
        for (int k = 0; k < 200; k++) begin
            out_ready = (readyMode == 0) ? 1'b1 : pat[k % 4];
            if (k == 0) begin
                start = 1'b1;
                base_addr = ADDR_W'(base);
                length = LEN_W'(len);
                startCycle = cycle;
            end else if (k == restartAt) begin
                start = 1'b1;
                base_addr = ADDR_W'(12);
                length = LEN_W'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (doneCount > 0) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("transfer_completes", int'(finished), 1);
        checkOutput("read_count", readCount, len);
        checkOutput("done_pulses", doneCount, 1);
        checkOutput("scoreboard_drained", expData.size(), 0);
        checkOutput("outstanding_le_2", int'(maxOutstanding <= 2), 1);
        checkOutput("busy_span", busyCount, doneCycle - startCycle);
        if (len > 0) checkOutput("done_after_last", doneCycle, lastPopCycle + 1);
    endtask

    initial begin
        int expAddr[4];
        expAddr = '{16382, 16383, 0, 1};
        clearCounters();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_mem_r_en", int'(mem_r_en), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: full 16-word block at full rate
        $display("[TB] test 1: base=0 len=16 ready=1");
        applyStimulus(0, 16, 0, -1);
        checkOutput("t1_first_latency", firstPopCycle - startCycle, 2);
        checkOutput("t1_back_to_back", lastPopCycle - firstPopCycle, 15);
        checkOutput("t1_reads_consecutive", lastReadCycle - firstReadCycle, 15);
        checkOutput("t1_busy_cycles", busyCount, 18);

        // 2: backpressure pattern
        $display("[TB] test 2: base=4 len=6 ready pattern 1,0,0,1");
        applyStimulus(4, 6, 1, -1);

        // 3: zero-length transfer
        $display("[TB] test 3: len=0");
        applyStimulus(0, 0, 0, -1);
        checkOutput("t3_busy_cycles", busyCount, 1);
        checkOutput("t3_done_cycle", doneCycle - startCycle, 1);
        checkOutput("t3_no_valid", validCount, 0);

        // 4: address wrap
        $display("[TB] test 4: base=16382 len=4");
        applyStimulus(16382, 4, 0, -1);
        checkOutput("t4_addr_count", addrLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < addrLog.size()) checkOutput("t4_addr", addrLog[i], expAddr[i]);
        end

        // 5: reset in the middle of a transfer
        $display("[TB] test 5: reset mid-transfer");
        clearCounters();
        pushExpected(0, 16);
        out_ready = 1'b1;
        start = 1'b1;
        base_addr = '0;
        length = LEN_W'(16);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (popCount >= 5) break;
            @(posedge clk);
            #1;
        end
        checkOutput("t5_words_before_reset", int'(popCount >= 5), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_busy", int'(busy), 0);
        checkOutput("t5_done", int'(done), 0);
        checkOutput("t5_mem_r_en", int'(mem_r_en), 0);
        checkOutput("t5_mem_addr", int'(mem_addr), 0);
        checkOutput("t5_out_valid", int'(out_valid), 0);
        checkOutput("t5_out_last", int'(out_last), 0);
        checkOutput("t5_out_data", int'(out_data), 0);
        expData.delete();
        expLast.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8, 2, 0, -1);

        // 6: second start while busy must be ignored
        $display("[TB] test 6: start during transfer");
        applyStimulus(0, 8, 1, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
